// File: rtl/fpu_pkg.sv
// fpu_pkg: definitions shared by the FPU converters.
//   - binary32 field geometry (std/man/exp/bias defaults)
//   - rounding-mode encodings shared with the float-to-integer converter
//   - FSM state enum of the integer-to-float converter
//   - round_inc(): round-up decision from mode, sign, lsb and G/R/S bits
package fpu_pkg;

   localparam int FPU_STD  = 31;   // MSB index of the float result
   localparam int FPU_MAN  = 22;   // MSB index of the stored mantissa
   localparam int FPU_EXP  = 7;    // MSB index of the exponent field
   localparam int FPU_BIAS = 127;  // exponent bias

   // Exponent of a magnitude whose leading one sits at bit 31.
   localparam logic [FPU_EXP:0] I2F_EXP_TOP = 8'(FPU_BIAS + 31);

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ABS  = 3'd1,
      ST_NORM = 3'd2,
      ST_RND  = 3'd3,
      ST_OUT  = 3'd4
   } i2f_state_e;

   // Increment decision; unused encodings 101-111 behave as RNE.
   function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                      input logic lsb, input logic g,
                                      input logic r, input logic s);
      logic inc;
      case (rm)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = (g | r | s) & sign;
         RM_RUP:  inc = (g | r | s) & ~sign;
         RM_RMM:  inc = g;
         default: inc = g & (r | s | lsb);
      endcase
      return inc;
   endfunction

endpackage

// File: rtl/fpu_int_to_float_if.sv
// fpu_int_to_float_if: request/response handshake of the integer-to-float
// converter.
//   request : in_valid, in_ready, in_int, in_rm, in_opcode_signed
//   response: out_valid, out_ready, out_float, out_inexact_flag
//   master = issue stage / consumer, slave = converter
interface fpu_int_to_float_if #(parameter int STD = 31);
   logic           in_valid;
   logic           in_ready;
   logic [31:0]    in_int;
   logic [2:0]     in_rm;
   logic           in_opcode_signed;
   logic           out_valid;
   logic           out_ready;
   logic [STD:0]   out_float;
   logic           out_inexact_flag;

   modport master (
      output in_valid, in_int, in_rm, in_opcode_signed, out_ready,
      input  in_ready, out_valid, out_float, out_inexact_flag
   );

   modport slave (
      input  in_valid, in_int, in_rm, in_opcode_signed, out_ready,
      output in_ready, out_valid, out_float, out_inexact_flag
   );
endinterface

// File: rtl/fpu_lzc32.sv
// fpu_lzc32: combinational 32-bit leading-zero counter.
//   value    in  32  operand
//   count    out 5   number of zeros above the leading one (0 when value is 0)
//   all_zero out 1   value is zero
module fpu_lzc32 (
   input  logic [31:0] value,
   output logic [4:0]  count,
   output logic        all_zero
);

   // Scan upward so the highest set bit is the last to write count.
   always_comb begin
      count = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (value[i]) begin
            count = 5'(31 - i);
         end else begin
            count = count;
         end
      end
   end

   assign all_zero = (value == 32'd0);

endmodule

// File: rtl/fpu_int_to_float.sv
// fpu_int_to_float: multi-cycle FCVT.S.W / FCVT.S.WU converter.
//   clk  in  clock
//   rst  in  synchronous reset, active-high
//   bus  slave modport of fpu_int_to_float_if (request and response handshakes)
// Sequence: IDLE -> ABS -> NORM -> RND -> OUT -> IDLE, one request in flight.
// Build option FPU_I2F_ZERO_BYPASS_EN: a zero operand jumps from IDLE straight
// to OUT (result +0, not inexact); otherwise zero takes the full path.
module fpu_int_to_float
   import fpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   fpu_int_to_float_if.slave  bus
);

   i2f_state_e         state_r, state_nxt_s;
   logic [31:0]        int_r;
   logic [2:0]         rm_r;
   logic               signed_r;
   logic               sign_r;
   logic [31:0]        mag_r;
   logic [4:0]         lzc_r;
   logic               zero_r;
   logic [FPU_MAN:0]   mant_r;
   logic [FPU_EXP:0]   exp_r;
   logic               g_r, r_r, s_r;
   logic [FPU_STD:0]   out_float_r;
   logic               inexact_r;

   logic               accept_s;
   logic               sign_s;
   logic [31:0]        mag_s;
   logic [4:0]         lzc_s;
   logic               lzc_zero_s;
   logic [30:0]        norm_s;
   logic               inc_s;
   logic [FPU_MAN+1:0] mant_inc_s;
   logic [FPU_EXP:0]   exp_rnd_s;

   assign bus.in_ready         = (state_r == ST_IDLE) && !rst;
   assign bus.out_valid        = (state_r == ST_OUT);
   assign bus.out_float        = out_float_r;
   assign bus.out_inexact_flag = inexact_r;
   assign accept_s             = bus.in_valid && bus.in_ready;

   // Magnitude of the captured operand; 0x80000000 signed negates to itself.
   assign sign_s = signed_r & int_r[31];
   assign mag_s  = sign_s ? (32'd0 - int_r) : int_r;

   fpu_lzc32 u_lzc (
      .value    (mag_s),
      .count    (lzc_s),
      .all_zero (lzc_zero_s)
   );

   // Leading one moves to bit 31, which is implicit and dropped.
   assign norm_s = 31'(mag_r << lzc_r);

   // Mantissa carry-out clears the stored mantissa and bumps the exponent.
   assign inc_s      = round_inc(rm_r, sign_r, mant_r[0], g_r, r_r, s_r);
   assign mant_inc_s = {1'b0, mant_r} + {{(FPU_MAN + 1){1'b0}}, inc_s};
   assign exp_rnd_s  = exp_r + {{FPU_EXP{1'b0}}, mant_inc_s[FPU_MAN+1]};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
`ifdef FPU_I2F_ZERO_BYPASS_EN
               if (bus.in_int == 32'd0) begin
                  state_nxt_s = ST_OUT;
               end else begin
                  state_nxt_s = ST_ABS;
               end
`else
               state_nxt_s = ST_ABS;
`endif
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ABS:  state_nxt_s = ST_NORM;
         ST_NORM: state_nxt_s = ST_RND;
         ST_RND:  state_nxt_s = ST_OUT;
         ST_OUT: begin
            if (bus.out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath: capture, absolute value, normalise, round and pack.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_r       <= 32'd0;
         rm_r        <= 3'd0;
         signed_r    <= 1'b0;
         sign_r      <= 1'b0;
         mag_r       <= 32'd0;
         lzc_r       <= 5'd0;
         zero_r      <= 1'b0;
         mant_r      <= '0;
         exp_r       <= '0;
         g_r         <= 1'b0;
         r_r         <= 1'b0;
         s_r         <= 1'b0;
         out_float_r <= '0;
         inexact_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  int_r       <= bus.in_int;
                  rm_r        <= bus.in_rm;
                  signed_r    <= bus.in_opcode_signed;
                  // Pre-clear the result so a bypassed zero presents +0 in OUT.
                  out_float_r <= '0;
                  inexact_r   <= 1'b0;
               end
            end
            ST_ABS: begin
               sign_r <= sign_s;
               mag_r  <= mag_s;
               lzc_r  <= lzc_s;
               zero_r <= lzc_zero_s;
            end
            ST_NORM: begin
               // Zero keeps exponent, mantissa and G/R/S at 0 so it packs to +0.
               if (zero_r) begin
                  mant_r <= '0;
                  exp_r  <= '0;
                  g_r    <= 1'b0;
                  r_r    <= 1'b0;
                  s_r    <= 1'b0;
               end else begin
                  mant_r <= norm_s[30:8];
                  exp_r  <= I2F_EXP_TOP - {3'd0, lzc_r};
                  g_r    <= norm_s[7];
                  r_r    <= norm_s[6];
                  s_r    <= |norm_s[5:0];
               end
            end
            ST_RND: begin
               out_float_r <= {sign_r, exp_rnd_s, mant_inc_s[FPU_MAN:0]};
               inexact_r   <= g_r | r_r | s_r;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/fpu_int_to_float.md
# fpu_int_to_float

Multi-cycle converter from a 32-bit signed or unsigned integer to an IEEE-754 binary32 float, implementing the FCVT.S.W / FCVT.S.WU direction of the FPU. It pairs with the float-to-integer converter and shares its rounding-mode encoding and its signed/unsigned opcode select. It sits behind the FPU issue stage with a valid/ready handshake on both sides and raises only the inexact flag; integer-to-float conversion cannot be invalid.

## Interface
- std, 31, MSB index of the float result
- man, 22, MSB index of the stored mantissa
- exp, 7, MSB index of the exponent field
- bias, 127, exponent bias
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request; high only in IDLE and never while rst is high
- in_int  in  32  integer operand
- in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 are treated as RNE
- in_opcode_signed  in  1  1 = two's-complement operand, 0 = unsigned operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_float  out  std+1  converted value
- out_inexact_flag  out  1  result is not exactly representable

## Operation
- Handshake: a request is accepted on a rising edge with in_valid && in_ready. in_int, in_rm and in_opcode_signed are captured only at that edge.
- FSM states: IDLE -> ABS -> NORM -> RND -> OUT -> IDLE.
  - ABS: sign = in_opcode_signed & in_int[31]. Magnitude = sign ? -in_int : in_int. 0x80000000 signed gives magnitude 0x80000000. Leading-zero count (5 bits) is computed here.
  - NORM: magnitude << lzc, so the MSB lands at bit 31. Mantissa = bits[30:8], guard = bit 7, round = bit 6, sticky = OR of bits[5:0]. Exponent = bias + 31 − lzc.
  - RND: increment decision:
    - RNE: G & (R|S|mant[0]).
    - RMM: G.
    - RUP: (G|R|S) & ~sign.
    - RDN: (G|R|S) & sign.
    - RTZ: never.
  - If the mantissa increment carries out, the mantissa becomes 0 and the exponent increments by 1. Overflow to infinity is impossible for 32-bit inputs.
  - Inexact = G|R|S.
- Zero input: result is +0 (0x00000000), inexact = 0, for every mode and signedness.
- OUT: out_valid is held high with out_float and out_inexact_flag stable until out_valid && out_ready. At that edge the FSM returns to IDLE.
- No request is accepted outside IDLE, so in_ready is low from ABS through OUT.

## Timing
- Latency: out_valid rises 4 clock edges after the accepting edge (IDLE->ABS->NORM->RND->OUT).
- Throughput: one conversion per 5 cycles with out_ready held high.
- Reset (any state, including mid-conversion): next edge gives state IDLE, out_valid 0, out_float 0, out_inexact_flag 0. The in-flight transaction is discarded and no result is emitted.
- out_ready is ignored when out_valid is low.
- in_valid is ignored outside IDLE, with no buffering.

## Configuration
- FPU_I2F_ZERO_BYPASS_EN
  - Defined: a zero operand accepted in IDLE goes directly to OUT, so out_valid rises 1 edge after acceptance.
  - Undefined: zero traverses all states with the normal 4-edge latency.
  - Results and flags are identical in both builds.

## Structure
- Shared package fpu_pkg holds:
  - the rounding-mode constants (RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM);
  - the FSM state enum;
  - the default std/man/exp/bias values.
- Sub-module fpu_lzc32: combinational 32-bit leading-zero counter used in ABS. It is instantiated once.
- Round/pack logic stays inline.

## Test plan
- Exact conversion and latency: signed 0x00000001, RNE -> 0x3F800000, inexact 0, out_valid exactly 4 edges after acceptance. Signed 0xFFFFFFFF (−1) -> 0xBF800000.
- Rounding, signed 0x7FFFFFFF:
  - RNE -> 0x4F000000, inexact 1.
  - RTZ -> 0x4EFFFFFF, inexact 1.
- Ties, signed 0x01000001:
  - RNE -> 0x4B800000.
  - RUP -> 0x4B800001.
  - RMM -> 0x4B800001.
  - All three set inexact 1.
- Extremes:
  - Signed 0x80000000 -> 0xCF000000, inexact 0.
  - Unsigned 0xFFFFFFFF, RUP -> 0x4F800000 (mantissa carry into the exponent).
  - Unsigned 0xFFFFFFFF, RDN -> 0x4F7FFFFF.
- Backpressure and reset:
  - Hold out_ready low for 5 cycles in OUT: out_float and out_inexact_flag stay stable and in_ready stays 0.
  - Assert rst in NORM: out_valid never rises, and in_ready is high on the first cycle after rst deasserts.
- Zero: 0x00000000 in all modes and both signednesses -> 0x00000000, inexact 0. Latency is 1 edge with FPU_I2F_ZERO_BYPASS_EN defined and 4 edges without it.
